// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared definitions for the NES gamepad reader.
//   - button bit indices inside the 8-bit button vector
//   - event codes presented to the grid controller
//   - frame FSM state encoding
//   - helpers that pick the event for a set of new presses / held buttons
package nes_pad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [3:0] CODE_NONE      = 4'd0;
  localparam logic [3:0] CODE_LEFT      = 4'd1;
  localparam logic [3:0] CODE_RIGHT     = 4'd2;
  localparam logic [3:0] CODE_DOWN      = 4'd3;
  localparam logic [3:0] CODE_ROT_CW    = 4'd4;
  localparam logic [3:0] CODE_ROT_CCW   = 4'd5;
  localparam logic [3:0] CODE_HARD_DROP = 4'd6;
  localparam logic [3:0] CODE_PAUSE     = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DECODE = 2'd3
  } frame_state_e;

  // Highest-priority newly pressed button: Start > A > B > Up > Down > Left > Right.
  function automatic logic [3:0] press_code(input logic [7:0] pressed);
    logic [3:0] code;
    if (pressed[BTN_START]) begin
      code = CODE_PAUSE;
    end else if (pressed[BTN_A]) begin
      code = CODE_ROT_CW;
    end else if (pressed[BTN_B]) begin
      code = CODE_ROT_CCW;
    end else if (pressed[BTN_UP]) begin
      code = CODE_HARD_DROP;
    end else if (pressed[BTN_DOWN]) begin
      code = CODE_DOWN;
    end else if (pressed[BTN_LEFT]) begin
      code = CODE_LEFT;
    end else if (pressed[BTN_RIGHT]) begin
      code = CODE_RIGHT;
    end else begin
      code = CODE_NONE;
    end
    return code;
  endfunction

  // Single held direction eligible for auto-repeat: Down > Left > Right.
  function automatic logic [3:0] held_dir(input logic [7:0] held);
    logic [3:0] code;
    if (held[BTN_DOWN]) begin
      code = CODE_DOWN;
    end else if (held[BTN_LEFT]) begin
      code = CODE_LEFT;
    end else if (held[BTN_RIGHT]) begin
      code = CODE_RIGHT;
    end else begin
      code = CODE_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/nes_serial_frame.sv
// nes_serial_frame: drives one latch/shift transaction with an NES pad.
//   clk, reset     : system clock, async active-low reset
//   start          : one-cycle strobe, begins a frame when idle
//   nes_data       : pad serial data (active-low buttons), asynchronous
//   nes_latch      : latch pulse to pad, 2*PULSE_CYCLES long
//   nes_clk        : shift clock, 7 high pulses between 8 low windows
//   frame_done     : high for the single DECODE cycle
//   frame_data     : captured buttons, active-high, bit i = i-th bit shifted out
// The frame is LATCH (2 slots) then SHIFT (15 slots: even = low window,
// odd = nes_clk high), each slot PULSE_CYCLES long, then one DECODE cycle.
// nes_data passes through a two-flop synchronizer, so the sampled value is
// the pad level two cycles before the end of the low window; the pad changes
// data only on the nes_clk rising edge, so PULSE_CYCLES must be at least 3.
module nes_serial_frame
  import nes_pad_pkg::*;
#(
  parameter int PULSE_CYCLES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic       frame_done,
  output logic [7:0] frame_data
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  frame_state_e  state_r, state_nx;
  logic [PW-1:0] pulse_r, pulse_nx;
  logic [3:0]    slot_r, slot_nx;
  logic [7:0]    data_r;
  logic          latch_r, clk_r;
  logic          sample_s;
  logic [1:0]    sync_r;

  // Bring the asynchronous pad data into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], nes_data};
    end
  end

  // Frame FSM next state, slot/pulse counters and sample strobe.
  always_comb begin
    state_nx = state_r;
    pulse_nx = pulse_r;
    slot_nx  = slot_r;
    sample_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_LATCH;
          pulse_nx = {PW{1'b0}};
          slot_nx  = 4'd0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (pulse_r == PULSE_LAST) begin
          pulse_nx = {PW{1'b0}};
          if (slot_r == 4'd1) begin
            state_nx = ST_SHIFT;
            slot_nx  = 4'd0;
          end else begin
            slot_nx = slot_r + 4'd1;
          end
        end else begin
          pulse_nx = pulse_r + PW'(1);
        end
      end
      ST_SHIFT: begin
        if (pulse_r == PULSE_LAST) begin
          pulse_nx = {PW{1'b0}};
          sample_s = ~slot_r[0];
          if (slot_r == 4'd14) begin
            state_nx = ST_DECODE;
            slot_nx  = 4'd0;
          end else begin
            slot_nx = slot_r + 4'd1;
          end
        end else begin
          pulse_nx = pulse_r + PW'(1);
        end
      end
      ST_DECODE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        pulse_nx = {PW{1'b0}};
        slot_nx  = 4'd0;
      end
    endcase
  end

  // State, counters and pad outputs; outputs follow the next state so they
  // are registered yet aligned with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      pulse_r <= {PW{1'b0}};
      slot_r  <= 4'd0;
      latch_r <= 1'b0;
      clk_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      pulse_r <= pulse_nx;
      slot_r  <= slot_nx;
      latch_r <= (state_nx == ST_LATCH);
      clk_r   <= (state_nx == ST_SHIFT) && slot_nx[0];
    end
  end

  // Shift register: first bit out of the pad lands in bit 0 after 8 shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && start) begin
      data_r <= 8'h00;
    end else if (sample_s) begin
      data_r <= {~sync_r[1], data_r[7:1]};
    end else begin
      data_r <= data_r;
    end
  end

  assign nes_latch  = latch_r;
  assign nes_clk    = clk_r;
  assign frame_done = (state_r == ST_DECODE);
  assign frame_data = data_r;

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad and turns button changes into move events.
//   clk, reset  : system clock, async active-low reset
//   nes_data    : pad serial data in (active-low)
//   nes_latch   : latch pulse to pad
//   nes_clk     : shift clock to pad
//   buttons     : button state of the last poll, active-high
//   button_code : one-cycle event code, 0 when idle
//   code_valid  : high exactly while button_code is non-zero
//   pad_reset   : one-cycle request on a fresh Start+Select chord
// The poll counter free-runs; its terminal count starts a frame. On the
// frame's DECODE cycle, edge detection, priority encoding and the
// auto-repeat counter produce at most one event.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES  = 833_333,
  parameter int PULSE_CYCLES = 300,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [3:0] button_code,
  output logic       code_valid,
  output logic       pad_reset
);

  localparam int PCW = $clog2(POLL_CYCLES);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_CYCLES - 1);
  // Repeat counter lives in DELAY..DELAY+RATE once repeating, so it never
  // needs to count past DELAY+RATE.
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY + REPEAT_RATE);

  logic [PCW-1:0] poll_cnt_r;
  logic           start_s;
  logic           frame_done_s;
  logic [7:0]     frame_data_s;

  logic [7:0]     buttons_r, prev_r;
  logic [RW-1:0]  rep_r, rep_nx, rep_inc_s;
  logic [3:0]     dir_r, dir_nx, dir_s, press_s, code_nx;
  logic [3:0]     code_r;
  logic           valid_r, pad_reset_r, pad_reset_nx;
  logic [7:0]     new_s;
  logic           chord_s, prev_chord_s;

  // Free-running poll counter; terminal count requests a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt_r <= {PCW{1'b0}};
    end else if (poll_cnt_r == POLL_LAST) begin
      poll_cnt_r <= {PCW{1'b0}};
    end else begin
      poll_cnt_r <= poll_cnt_r + PCW'(1);
    end
  end

  assign start_s = (poll_cnt_r == POLL_LAST);

  nes_serial_frame #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .start      (start_s),
    .nes_data   (nes_data),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .frame_done (frame_done_s),
    .frame_data (frame_data_s)
  );

  assign new_s        = frame_data_s & ~prev_r;
  assign chord_s      = frame_data_s[BTN_START] & frame_data_s[BTN_SELECT];
  assign prev_chord_s = prev_r[BTN_START] & prev_r[BTN_SELECT];
  assign press_s      = press_code(new_s);
  assign dir_s        = held_dir(frame_data_s);
  assign rep_inc_s    = rep_r + RW'(1);

  // Event selection for the poll being decoded.
  always_comb begin
    code_nx      = CODE_NONE;
    pad_reset_nx = 1'b0;
    rep_nx       = rep_r;
    dir_nx       = dir_r;
    if (chord_s && !prev_chord_s) begin
      pad_reset_nx = 1'b1;
      rep_nx       = {RW{1'b0}};
      dir_nx       = CODE_NONE;
    end else if (chord_s) begin
      rep_nx = {RW{1'b0}};
      dir_nx = CODE_NONE;
    end else if (press_s != CODE_NONE) begin
      code_nx = press_s;
      rep_nx  = {RW{1'b0}};
      dir_nx  = dir_s;
    end else if ((dir_s != CODE_NONE) && (dir_s == dir_r)) begin
      rep_nx = rep_inc_s;
      if (rep_inc_s == REP_FIRST) begin
        code_nx = dir_s;
      end else if (rep_inc_s == REP_NEXT) begin
        code_nx = dir_s;
        rep_nx  = REP_FIRST;
      end else begin
        code_nx = CODE_NONE;
      end
    end else begin
      // Direction changed or released: restart the hold count.
      rep_nx = {RW{1'b0}};
      dir_nx = dir_s;
    end
  end

  // Poll state and one-cycle event outputs, updated only on DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buttons_r   <= 8'h00;
      prev_r      <= 8'h00;
      rep_r       <= {RW{1'b0}};
      dir_r       <= CODE_NONE;
      code_r      <= CODE_NONE;
      valid_r     <= 1'b0;
      pad_reset_r <= 1'b0;
    end else if (frame_done_s) begin
      buttons_r   <= frame_data_s;
      prev_r      <= frame_data_s;
      rep_r       <= rep_nx;
      dir_r       <= dir_nx;
      code_r      <= code_nx;
      valid_r     <= (code_nx != CODE_NONE);
      pad_reset_r <= pad_reset_nx;
    end else begin
      code_r      <= CODE_NONE;
      valid_r     <= 1'b0;
      pad_reset_r <= 1'b0;
    end
  end

  assign buttons     = buttons_r;
  assign button_code = code_r;
  assign code_valid  = valid_r;
  assign pad_reset   = pad_reset_r;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed bench for nes_pad_reader with a 4021-style
// pad model (load on latch, shift on nes_clk rising edge).
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk;
  logic [7:0] buttons;
  logic [3:0] button_code;
  logic       code_valid, pad_reset;

  logic [7:0] pad_btn = 8'h00;
  logic [7:0] pad_sr  = 8'hFF;

  int vec_cnt = 0;
  int miscompares = 0;
  logic [3:0] ev_q[$];
  int rst_pulses = 0;
  int overlap_cnt = 0;
  int valid_bad_cnt = 0;

  nes_pad_reader #(
    .POLL_CYCLES  (200),
    .PULSE_CYCLES (4),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nes_data    (nes_data),
    .nes_latch   (nes_latch),
    .nes_clk     (nes_clk),
    .buttons     (buttons),
    .button_code (button_code),
    .code_valid  (code_valid),
    .pad_reset   (pad_reset)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift toward bit 0 on nes_clk.
  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) pad_sr <= ~pad_btn;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign nes_data = pad_sr[0];

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (code_valid === 1'b1) ev_q.push_back(button_code);
    if (pad_reset === 1'b1) rst_pulses <= rst_pulses + 1;
    if (nes_latch === 1'b1 && nes_clk === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (code_valid !== (button_code != 4'd0)) valid_bad_cnt <= valid_bad_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next latch, then let the whole frame and its decode finish.
  task automatic next_poll(input string tag);
    int n;
    n = 0;
    ev_q.delete();
    rst_pulses = 0;
    while (nes_latch !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latch_seen"}, 32'(n < 400), 32'd1);
    repeat (80) @(posedge clk);
    #1;
  endtask

  // Count cycles from reset release until the latch rises.
  task automatic latch_delay(input string tag);
    int k;
    k = 0;
    while (k < 400) begin
      @(posedge clk); #1;
      k++;
      if (nes_latch === 1'b1) break;
    end
    check(tag, 32'(k), 32'd200);
  endtask

  initial begin
    int len, pulses, hi;
    logic prev_c;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_nes_clk", 32'(nes_clk), 32'd0);
    check("rst_buttons", 32'(buttons), 32'h00);
    check("rst_code", 32'(button_code), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_pad_reset", 32'(pad_reset), 32'd0);

    // First frame with idle pad: latch timing and shift clock shape
    @(negedge clk);
    reset = 1'b1;
    latch_delay("first_latch_cycle");
    len = 0;
    while (nes_latch === 1'b1 && len < 50) begin
      len++;
      @(posedge clk); #1;
    end
    check("latch_len", 32'(len), 32'd8);
    pulses = 0;
    hi = 0;
    prev_c = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (nes_clk === 1'b1 && prev_c === 1'b0) pulses++;
      if (nes_clk === 1'b1) hi++;
      prev_c = nes_clk;
      @(posedge clk); #1;
    end
    check("nes_clk_pulses", 32'(pulses), 32'd7);
    check("nes_clk_high_cycles", 32'(hi), 32'd28);
    repeat (10) @(posedge clk);
    #1;
    check("idle_buttons", 32'(buttons), 32'h00);
    check("idle_no_code", 32'(ev_q.size()), 32'd0);

    // A + Left in the same poll: one rotate-CW event, then nothing
    pad_btn = 8'h41;
    next_poll("aleft1");
    check("aleft_buttons", 32'(buttons), 32'h41);
    check("aleft_events", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) check("aleft_code", 32'(ev_q[0]), 32'd4);
    next_poll("aleft2");
    check("aleft_held_events", 32'(ev_q.size()), 32'd0);

    // Release, then hold Right for 8 polls
    pad_btn = 8'h00;
    next_poll("release");
    check("release_events", 32'(ev_q.size()), 32'd0);
    pad_btn = 8'h80;
    for (int p = 1; p <= 8; p++) begin
      next_poll("right");
      if (p == 1 || p == 4 || p == 6 || p == 8) begin
        check($sformatf("right_poll%0d_events", p), 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) check($sformatf("right_poll%0d_code", p), 32'(ev_q[0]), 32'd2);
      end else begin
        check($sformatf("right_poll%0d_events", p), 32'(ev_q.size()), 32'd0);
      end
    end

    // Start + Select chord: one pad_reset pulse, no pause code
    pad_btn = 8'h00;
    next_poll("release2");
    pad_btn = 8'h0C;
    next_poll("chord1");
    check("chord_buttons", 32'(buttons), 32'h0C);
    check("chord_pad_reset_cycles", 32'(rst_pulses), 32'd1);
    check("chord_events", 32'(ev_q.size()), 32'd0);
    next_poll("chord2");
    check("chord_held_pad_reset", 32'(rst_pulses), 32'd0);
    check("chord_held_events", 32'(ev_q.size()), 32'd0);

    // Reset in the middle of SHIFT while nes_clk is high
    pad_btn = 8'h01;
    len = 0;
    while (nes_latch !== 1'b1 && len < 400) begin
      @(posedge clk); #1;
      len++;
    end
    repeat (13) @(posedge clk);
    #1;
    check("midframe_nes_clk_high", 32'(nes_clk), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_nes_clk", 32'(nes_clk), 32'd0);
    check("midrst_latch", 32'(nes_latch), 32'd0);
    check("midrst_buttons", 32'(buttons), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    ev_q.delete();
    latch_delay("midrst_next_latch_cycle");
    repeat (80) @(posedge clk);
    #1;
    check("post_rst_buttons", 32'(buttons), 32'h01);
    check("post_rst_events", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) check("post_rst_code", 32'(ev_q[0]), 32'd4);

    check("latch_clk_overlap", 32'(overlap_cnt), 32'd0);
    check("valid_vs_code", 32'(valid_bad_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Polls an NES gamepad over its 3-wire serial interface, captures the 8 button states once per poll period, and converts them into single-cycle move events for the grid controller. Sits between the board's controller connector and the grid controller's 4-bit `controller_in`. Also raises a one-cycle pad reset request on a Start+Select chord.

## Interface
- `POLL_CYCLES`, 833_333: clk cycles between poll starts (60 Hz at 50 MHz); must exceed 17*`PULSE_CYCLES`+2
- `PULSE_CYCLES`, 300: length of one latch/clock half-period in clk cycles (6 µs at 50 MHz)
- `REPEAT_DELAY`, 16: polls a direction must be held before the first auto-repeat
- `REPEAT_RATE`, 4: polls between later auto-repeats
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: asynchronous, active-low reset (asserted at 0)
- `nes_data` in 1: serial data from pad, active-low per button
- `nes_latch` out 1: latch pulse to pad
- `nes_clk` out 1: shift clock to pad
- `buttons` out 8: debounced-by-poll state, active-high; bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- `button_code` out 4: event code, 0 when idle
- `code_valid` out 1: high for exactly the cycle `button_code` is non-zero
- `pad_reset` out 1: one-cycle reset request

## Operation
- Event codes: 0 none, 1 left, 2 right, 3 down (soft drop), 4 rotate CW (A), 5 rotate CCW (B), 6 hard drop (Up), 7 pause (Start).
- Frame FSM: IDLE → LATCH → SHIFT → DECODE → IDLE.
  - IDLE: poll counter counts 0..`POLL_CYCLES`-1; at terminal count, enter LATCH. The counter runs continuously and is never stalled by the frame.
  - LATCH: `nes_latch`=1 for 2*`PULSE_CYCLES` cycles, then 0.
  - SHIFT: 8 low windows of `PULSE_CYCLES` cycles each, separated by 7 high pulses of `nes_clk`. Bit i is sampled as `~nes_data` on the last cycle of low window i. `nes_clk` is low during every low window.
  - DECODE: one cycle. `buttons` is updated, then an event is chosen.
- Decode rules, with new = current & ~previous:
  - Start and Select both held and not both held on the previous poll: `pad_reset` pulses and no code is emitted.
  - Start and Select both held otherwise: no code is emitted.
  - Otherwise the highest-priority new press emits its code. Priority: Start > A > B > Up > Down > Left > Right.
  - With no new press, auto-repeat applies to the single held direction chosen by Down > Left > Right.
  - The repeat counter increments once per poll while that direction stays selected. A code fires when the counter equals `REPEAT_DELAY`, then every `REPEAT_RATE` polls after that.
  - The repeat counter clears when the selected direction changes or is released, and when a new-press event fires.
- Reset mid-frame: all state is returned immediately; a partial frame is discarded.

## Timing
- Reset values: `nes_latch` 0, `nes_clk` 0, `buttons` 0, `button_code` 0, `code_valid` 0, `pad_reset` 0, FSM IDLE, poll counter 0, previous buttons 0, repeat counter 0.
- The first LATCH begins `POLL_CYCLES` cycles after reset deasserts.
- Frame length, LATCH start to DECODE, is 17*`PULSE_CYCLES` cycles. `buttons`, `button_code`, `code_valid` and `pad_reset` are all registered and change on the cycle after DECODE.
- `button_code`/`code_valid` and `pad_reset` are high for one cycle and return to 0 on the next cycle.
- At most one event is emitted per poll.
- `nes_latch` and `nes_clk` are never high in the same cycle.

## Structure
- Package `nes_pad_pkg` holds:
  - button bit indices
  - event code constants
  - the frame FSM state enum
- Sub-module `nes_serial_frame` owns the LATCH/SHIFT timing and the 8-bit shift register. It takes a start strobe and returns `frame_done` plus the 8-bit result.
- The parent holds the poll counter, edge detection, priority encoder and repeat logic.

## Test plan
Bench parameters: `POLL_CYCLES`=200, `PULSE_CYCLES`=4, `REPEAT_DELAY`=3, `REPEAT_RATE`=2.

- Pad model idle (all ones), reset released → first latch rises at cycle 200 and lasts 8 cycles; 7 `nes_clk` pulses of 4 cycles; `buttons`=0; no `code_valid`.
- Pad presses A and Left in the same poll → `buttons`=8'h41 and a single code 4; on the next poll with both still held, no code.
- Right held for 8 polls → code 2 on poll 1; repeats on polls 4, 6 and 8; no code on the other polls.
- Start+Select pressed together → `pad_reset` pulses for 1 cycle; no code 7; still held next poll → nothing.
- Reset asserted in the middle of SHIFT → `nes_clk`/`nes_latch` go to 0 immediately and `buttons` becomes 0; after release, the next latch occurs 200 cycles later.
